// File: rtl/ex_mem_pkg.sv
// Shared types for the execute-to-memory pipeline stage.
// The optional forwarding port set is enabled with the EX_MEM_FWD_EN macro in ex_mem_stage.
package ex_mem_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            reg_write;
    } ex_mem_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/word_sext64.sv
// RV64 W-op result extension: replicates bit 31 into the upper word when i_is_word is set.
// Shared with the word-op shifter datapath.
module word_sext64 (
    input  logic        i_is_word,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    assign o_data = i_is_word ? {{32{i_data[31]}}, i_data[31:0]} : i_data;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer with registered in_ready and W-op sign extension.
// Define EX_MEM_FWD_EN to add the fwd_valid/fwd_rd/fwd_data operand-forwarding outputs.
//
// state | meaning
// EMPTY | nothing held, in_ready=1
// ONE   | head valid, in_ready=1
// FULL  | head and skid valid, in_ready=0
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write
`ifdef EX_MEM_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    occ_t          r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    ex_mem_entry_t r_head;
    ex_mem_entry_t r_skid;

    logic [XLEN-1:0] w_result;
    ex_mem_entry_t   w_new;
    logic            w_accept;
    logic            w_drain;

    word_sext64 u_sext (
        .i_is_word (in_is_word),
        .i_data    (alu_result),
        .o_data    (w_result)
    );

    // Writes to x0 are architecturally dropped, so strip the enable at capture.
    assign w_new.result    = w_result;
    assign w_new.rd        = in_rd;
    assign w_new.reg_write = in_reg_write & (in_rd != '0);

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state          <= EMPTY;
            r_in_ready       <= 1'b1;
            r_out_valid      <= 1'b0;
            r_head.reg_write <= 1'b0;
            r_skid.reg_write <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_head      <= w_new;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_drain) begin
                        r_skid     <= w_new;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && w_drain) begin
                        r_head <= w_new;
                    end else if (w_drain) begin
                        r_head.reg_write <= 1'b0;
                        r_state          <= EMPTY;
                        r_out_valid      <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        r_head           <= r_skid;
                        r_skid.reg_write <= 1'b0;
                        r_state          <= ONE;
                        r_in_ready       <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_head      <= '0;
                    r_skid      <= '0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_result    = r_head.result;
    assign out_rd        = r_head.rd;
    assign out_reg_write = r_head.reg_write & r_out_valid;

`ifdef EX_MEM_FWD_EN
    ex_mem_entry_t w_young;

    assign w_young   = (r_state == FULL) ? r_skid : r_head;
    assign fwd_valid = (r_state != EMPTY) & w_young.reg_write;
    assign fwd_rd    = w_young.rd;
    assign fwd_data  = w_young.result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps plus random traffic against a queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_is_word;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
`endif

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_is_word    (in_is_word),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
`endif
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model, then advance one clock and update the model.
    task automatic cycle(input string tag);
        bit   acc, drn, fl;
        exp_t e;
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            chk({tag, ":out_result"}, out_result, q[0].res);
            chk({tag, ":out_rd"}, 64'(out_rd), 64'(q[0].rd));
            chk({tag, ":out_reg_write"}, 64'(out_reg_write), 64'(q[0].rw));
        end else begin
            chk({tag, ":idle_reg_write"}, 64'(out_reg_write), 64'd0);
        end
`ifdef EX_MEM_FWD_EN
        chk({tag, ":fwd_valid"}, 64'(fwd_valid), 64'(q.size() != 0 && q[$].rw));
        if (q.size() != 0 && q[$].rw) begin
            chk({tag, ":fwd_data"}, fwd_data, q[$].res);
            chk({tag, ":fwd_rd"}, 64'(fwd_rd), 64'(q[$].rd));
        end
`endif
        acc   = in_valid && (q.size() < 2);
        drn   = (q.size() != 0) && out_ready;
        fl    = flush;
        e.res = in_is_word ? 64'($signed(alu_result[31:0])) : alu_result;
        e.rd  = in_rd;
        e.rw  = in_reg_write && (in_rd != 5'd0);
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [4:0] rd, input logic rw, input logic w);
        in_valid     = 1'b1;
        alu_result   = a;
        in_rd        = rd;
        in_reg_write = rw;
        in_is_word   = w;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; in_rd = '0;
        in_reg_write = 1'b0; in_is_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset:out_valid", 64'(out_valid), 64'd0);
        chk("reset:in_ready", 64'(in_ready), 64'd1);
        chk("reset:out_result", out_result, 64'd0);
        chk("reset:out_rd", 64'(out_rd), 64'd0);
        chk("reset:out_reg_write", 64'(out_reg_write), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // W-op sign extension, then the same value as a full-width op
        out_ready = 1'b1;
        push(64'h0000_0000_8000_0000, 5'd3, 1'b1, 1'b1);
        cycle("wop_push");
        in_valid = 1'b0;
        chk("wop:out_result", out_result, 64'hFFFF_FFFF_8000_0000);
        chk("wop:out_rd", 64'(out_rd), 64'd3);
        cycle("wop_out");
        push(64'h0000_0000_8000_0000, 5'd3, 1'b1, 1'b0);
        cycle("dop_push");
        in_valid = 1'b0;
        chk("dop:out_result", out_result, 64'h0000_0000_8000_0000);
        cycle("dop_out");

        // Write to x0 is suppressed
        push(64'hFFFF, 5'd0, 1'b1, 1'b0);
        cycle("x0_push");
        in_valid = 1'b0;
        chk("x0:out_valid", 64'(out_valid), 64'd1);
        chk("x0:out_reg_write", 64'(out_reg_write), 64'd0);
        cycle("x0_out");

        // Backpressure: A, B fill the buffer, C is held by the source
        out_ready = 1'b0;
        push(64'h11, 5'd1, 1'b1, 1'b0); cycle("bp_a");
        push(64'h22, 5'd2, 1'b1, 1'b0); cycle("bp_b");
        push(64'h33, 5'd3, 1'b1, 1'b0);
        chk("bp:in_ready_full", 64'(in_ready), 64'd0);
        cycle("bp_c_held");
        cycle("bp_c_held2");
        out_ready = 1'b1;
        chk("bp:order_a", out_result, 64'h11);
        cycle("bp_drain_a");
        chk("bp:order_b", out_result, 64'h22);
        cycle("bp_drain_b");
        in_valid = 1'b0;
        chk("bp:order_c", out_result, 64'h33);
        cycle("bp_drain_c");
        cycle("bp_empty");

        // Full-throughput stream with simultaneous accept and drain
        for (int i = 0; i < 256; i++) begin
            push(64'(i) ^ {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'b1, 1'($urandom));
            cycle("stream");
            if (i > 0) chk("stream:in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cycle("stream_tail");

        // Flush while FULL with an incoming entry
        out_ready = 1'b0;
        push(64'h55, 5'd5, 1'b1, 1'b0); cycle("fl_a");
        push(64'h66, 5'd6, 1'b1, 1'b0); cycle("fl_b");
        push(64'h77, 5'd7, 1'b1, 1'b0);
        flush = 1'b1;
        cycle("fl_flush");
        flush = 1'b0; in_valid = 1'b0;
        chk("flush:out_valid", 64'(out_valid), 64'd0);
        chk("flush:in_ready", 64'(in_ready), 64'd1);
        chk("flush:out_reg_write", 64'(out_reg_write), 64'd0);
        out_ready = 1'b1;
        push(64'h44, 5'd4, 1'b1, 1'b0); cycle("fl_next");
        in_valid = 1'b0;
        chk("flush:next_result", out_result, 64'h44);
        cycle("fl_next_out");

        // Asynchronous reset mid-cycle while ONE
        out_ready = 1'b0;
        push(64'hDEAD_BEEF, 5'd9, 1'b1, 1'b0); cycle("ar_push");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset:out_valid", 64'(out_valid), 64'd0);
        chk("areset:in_ready", 64'(in_ready), 64'd1);
        chk("areset:out_result", out_result, 64'd0);
        chk("areset:out_rd", 64'(out_rd), 64'd0);
        chk("areset:out_reg_write", 64'(out_reg_write), 64'd0);
        q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        push(64'h1234, 5'd10, 1'b1, 1'b0); cycle("ar_after_push");
        in_valid = 1'b0;
        chk("areset:after_push", out_result, 64'h1234);
        cycle("ar_after_out");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid     = 1'($urandom_range(0, 3) != 0);
            alu_result   = {$urandom, $urandom};
            in_rd        = 5'($urandom_range(0, 31));
            in_reg_write = 1'($urandom);
            in_is_word   = 1'($urandom);
            out_ready    = 1'($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cycle("final1");
        cycle("final2");
        cycle("final3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
